// File: rtl/l2_evict_write_buffer.sv
// Eviction write buffer between the L2 and memory: absorbs dirty victims, drains them
// when idle, passes fills through. Define EWB_FORWARD_EN to serve fills that hit a buffered victim.
module l2_evict_write_buffer #(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         l2_pmem_read,
    input  logic         l2_pmem_write,
    input  logic [15:0]  l2_pmem_address,
    input  logic [15:0]  l2_pmem_waddress,
    input  logic [255:0] l2_pmem_wdata,
    output logic [255:0] l2_pmem_rdata,
    output logic         l2_pmem_resp,
    output logic         ewb_ready,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [2:0]   dbg_state_o,
    output logic [2:0]   dbg_count_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WACK  = 3'd1,
        RMEM  = 3'd2,
        RACK  = 3'd3,
        DRAIN = 3'd4
`ifdef EWB_FORWARD_EN
        , FWD = 3'd5
`endif
    } state_e;

    localparam logic [2:0] CNT_DEPTH = 3'(DEPTH);

    state_e       state_q, state_d;
    logic [3:0]   valid_q;
    logic [10:0]  line_q [4];
    logic [255:0] data_q [4];
    logic [1:0]   head_q, tail_q;
    logic [2:0]   count_q;
    logic         resp_q, rd_q, wr_q;
    logic [10:0]  rd_line_q;
    logic [255:0] rdata_q;

    logic         wmatch, rmatch, push, merge, pop, resp_d;
    logic [1:0]   widx, ridx;
    logic         unused_bits;

    function automatic logic [1:0] nxt_ptr(input logic [1:0] p);
        return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // Lines in the buffer are unique (victims to a buffered line merge), so at most one hit.
    always_comb begin
        wmatch = 1'b0;
        rmatch = 1'b0;
        widx   = '0;
        ridx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && line_q[i] == l2_pmem_waddress[15:5]) begin
                wmatch = 1'b1;
                widx   = 2'(i);
            end
            if (valid_q[i] && line_q[i] == l2_pmem_address[15:5]) begin
                rmatch = 1'b1;
                ridx   = 2'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        merge   = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (l2_pmem_write && count_q < CNT_DEPTH) begin
                    state_d = WACK;
                    merge   = wmatch;
                    push    = !wmatch;
                end else if (l2_pmem_write) begin
                    state_d = DRAIN;
                end else if (l2_pmem_read && rmatch) begin
`ifdef EWB_FORWARD_EN
                    state_d = FWD;
`else
                    state_d = DRAIN;
`endif
                end else if (l2_pmem_read) begin
                    state_d = RMEM;
                end else if (count_q != 3'd0) begin
                    state_d = DRAIN;
                end
            end
            RMEM:  if (pmem_resp) state_d = RACK;
            DRAIN: begin
                if (pmem_resp) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        resp_d = (state_d == WACK) || (state_d == RACK);
`ifdef EWB_FORWARD_EN
        resp_d = resp_d || (state_d == FWD);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            valid_q   <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            resp_q    <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            rd_line_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            resp_q  <= resp_d;
            rd_q    <= (state_d == RMEM);
            wr_q    <= (state_d == DRAIN);
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= nxt_ptr(tail_q);
                count_q         <= count_q + 3'd1;
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= nxt_ptr(head_q);
                count_q         <= count_q - 3'd1;
            end
            if (state_q == IDLE && state_d == RMEM) rd_line_q <= l2_pmem_address[15:5];
            if (state_q == RMEM && pmem_resp) rdata_q <= pmem_rdata;
`ifdef EWB_FORWARD_EN
            if (state_d == FWD) rdata_q <= data_q[ridx];
`endif
        end
    end

    // Payload storage needs no reset: an entry is only read while its valid bit is set.
    always_ff @(posedge clk) begin
        if (push) begin
            line_q[tail_q] <= l2_pmem_waddress[15:5];
            data_q[tail_q] <= l2_pmem_wdata;
        end else if (merge) begin
            data_q[widx] <= l2_pmem_wdata;
        end
    end

    assign ewb_ready     = count_q < CNT_DEPTH;
    assign l2_pmem_resp  = resp_q;
    assign l2_pmem_rdata = resp_q ? rdata_q : '0;
    assign pmem_read     = rd_q;
    assign pmem_write    = wr_q;
    assign pmem_address  = wr_q ? {line_q[head_q], 5'b0} : (rd_q ? {rd_line_q, 5'b0} : 16'h0);
    assign pmem_wdata    = wr_q ? data_q[head_q] : '0;
    assign dbg_state_o   = state_q;
    assign dbg_count_o   = count_q;

    assign unused_bits = ^{l2_pmem_address[4:0], l2_pmem_waddress[4:0], valid_q, ridx};

endmodule
